ser_2_par_pack: RTL and testbench

Upstream packer for `par_2_ser`. It accepts a stream of 50-bit serial words with a valid/ready handshake and groups each `CYCLE_TIMES` consecutive words into one line. It tags each line with a 9-bit line index and writes the resulting 509-bit word into the line FIFO that `par_2_ser` drains. Chunk placement and per-word bit reversal are the exact inverse of the unpacker, so a word entering here leaves `par_2_ser` unchanged, at memory address `line*10 + k`.

---
 rtl/par_ser_pkg.sv | 28 ++
 rtl/ser_2_par_pack_if.sv | 26 ++
 rtl/ser_2_par_pack.sv | 98 +++++++++
 tb/tb_ser_2_par_pack.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/par_ser_pkg.sv
// Constants and helpers shared by ser_2_par_pack and par_2_ser: line geometry,
// per-word bit reversal, and the memory address of word k within a line.
package par_ser_pkg;

  localparam int PAR_WIDTH   = 509;
  localparam int SER_WIDTH   = 50;
  localparam int CYCLE_TIMES = 10;
  localparam int LINE_WIDTH  = 9;
  localparam int ADDR_WIDTH  = 13;

  typedef enum logic {
    ST_FILL,
    ST_HOLD
  } pack_state_t;

  function automatic logic [SER_WIDTH-1:0] bitrev_ser(input logic [SER_WIDTH-1:0] d);
    logic [SER_WIDTH-1:0] r;
    for (int i = 0; i < SER_WIDTH; i++) r[i] = d[SER_WIDTH-1-i];
    return r;
  endfunction

  // 511*10+9 = 5119 still fits in 13 bits.
  function automatic logic [ADDR_WIDTH-1:0] line_addr(input logic [LINE_WIDTH-1:0] line,
                                                      input logic [3:0]            k);
    return ADDR_WIDTH'(line) * ADDR_WIDTH'(CYCLE_TIMES) + ADDR_WIDTH'(k);
  endfunction

endpackage

// File: rtl/ser_2_par_pack_if.sv
// Serial-in handshake plus line-FIFO write port of the packer.
// slave = packer side, master = producer/FIFO side.
interface ser_2_par_pack_if
  import par_ser_pkg::*;
;
  logic                  din_valid_i;
  logic [SER_WIDTH-1:0]  din_i;
  logic                  din_ready_o;
  logic [LINE_WIDTH-1:0] line_idx_i;
  logic                  line_abort_i;
  logic                  fifoFull_i;
  logic                  fifoWr_o;
  logic [PAR_WIDTH-1:0]  fifoDin_o;
  logic [15:0]           line_cnt_o;

  modport slave (
    input  din_valid_i, din_i, line_idx_i, line_abort_i, fifoFull_i,
    output din_ready_o, fifoWr_o, fifoDin_o, line_cnt_o
  );

  modport master (
    output din_valid_i, din_i, line_idx_i, line_abort_i, fifoFull_i,
    input  din_ready_o, fifoWr_o, fifoDin_o, line_cnt_o
  );

endinterface

// File: rtl/ser_2_par_pack.sv
// Packs CYCLE_TIMES serial words (bit-reversed, word 0 in the top chunk) plus a line index into one FIFO word.
// Write strobe one cycle after the last word; ready drops only once both acc and out hold full lines.
module ser_2_par_pack
  import par_ser_pkg::*;
(
  input logic              aclk_i,
  input logic              areset_i,
  ser_2_par_pack_if.slave  bus
);

  localparam int CNT_W = $clog2(CYCLE_TIMES);
  localparam int ACC_W = SER_WIDTH * CYCLE_TIMES;

  if (PAR_WIDTH != LINE_WIDTH + SER_WIDTH * CYCLE_TIMES) begin : g_bad_width
    $error("PAR_WIDTH must equal LINE_WIDTH + SER_WIDTH*CYCLE_TIMES");
  end

  pack_state_t           state;
  logic [CNT_W-1:0]      cnt;
  logic [ACC_W-1:0]      acc;
  logic [ACC_W-1:0]      acc_nxt;
  logic [LINE_WIDTH-1:0] idx;
  logic [PAR_WIDTH-1:0]  out_q;
  logic                  out_valid;
  logic                  rdy_q;
  logic [15:0]           line_cnt;
  logic                  fifo_wr;
  logic                  out_free;
  logic                  hs;
  logic                  last_word;

  assign fifo_wr   = out_valid & ~bus.fifoFull_i;
  assign out_free  = ~out_valid | fifo_wr;
  assign hs        = bus.din_valid_i & rdy_q;
  assign last_word = (cnt == CNT_W'(CYCLE_TIMES - 1));

  always_comb begin
    acc_nxt = acc;
    acc_nxt[SER_WIDTH*(CYCLE_TIMES-1-int'(cnt)) +: SER_WIDTH] = bitrev_ser(bus.din_i);
  end

  always_ff @(posedge aclk_i or posedge areset_i) begin
    if (areset_i) begin
      state     <= ST_FILL;
      cnt       <= '0;
      acc       <= '0;
      idx       <= '0;
      out_q     <= '0;
      out_valid <= 1'b0;
      rdy_q     <= 1'b0;
      line_cnt  <= '0;
    end else begin
      // A commit below overrides this clear, keeping out_valid set on reload.
      if (fifo_wr) begin
        out_valid <= 1'b0;
        line_cnt  <= line_cnt + 16'd1;
      end
      case (state)
        ST_FILL: begin
          rdy_q <= 1'b1;
          if (bus.line_abort_i) begin
            cnt <= '0;
          end else if (hs) begin
            acc <= acc_nxt;
            if (cnt == '0) idx <= bus.line_idx_i;
            if (last_word) begin
              cnt <= '0;
              if (out_free) begin
                out_q     <= {idx, acc_nxt};
                out_valid <= 1'b1;
              end else begin
                state <= ST_HOLD;
                rdy_q <= 1'b0;
              end
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        ST_HOLD: begin
          if (out_free) begin
            out_q     <= {idx, acc};
            out_valid <= 1'b1;
            state     <= ST_FILL;
            rdy_q     <= 1'b1;
          end
        end
        default: state <= ST_FILL;
      endcase
    end
  end

  assign bus.din_ready_o = rdy_q;
  assign bus.fifoWr_o    = fifo_wr;
  assign bus.fifoDin_o   = out_q;
  assign bus.line_cnt_o  = line_cnt;

endmodule

// File: tb/tb_ser_2_par_pack.sv
// Directed bench for ser_2_par_pack: reset, single line, back-to-back lines,
// FIFO back-pressure, abort and mid-line reset, with hand-computed expectations.
module tb_ser_2_par_pack;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  ser_2_par_pack_if bus();

  ser_2_par_pack dut (
    .aclk_i   (clk),
    .areset_i (rst),
    .bus      (bus)
  );

  int n_checks  = 0;
  int n_fail    = 0;
  int cyc       = 0;
  int stall_cnt = 0;

  logic [508:0] wr_q[$];
  int           wr_cyc[$];

  always @(posedge clk) cyc <= cyc + 1;

  always begin
    @(negedge clk);
    #1;
    if (!rst && bus.fifoWr_o) begin
      wr_q.push_back(bus.fifoDin_o);
      wr_cyc.push_back(cyc);
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", n_checks);
    $fatal(1);
  end

  task automatic check_val(input string tag, input logic [508:0] got, input logic [508:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [49:0] rev50(input logic [49:0] d);
    logic [49:0] r;
    for (int i = 0; i < 50; i++) r[i] = d[49-i];
    return r;
  endfunction

  function automatic logic [508:0] mk_line(input logic [8:0] li, input logic [49:0] w[10]);
    logic [508:0] r;
    r = '0;
    r[508:500] = li;
    for (int k = 0; k < 10; k++) r[50*(9-k) +: 50] = rev50(w[k]);
    return r;
  endfunction

  // Called and returns on a falling edge; the handshake is on the rising edge in between.
  task automatic send(input logic [49:0] d, input logic [8:0] li);
    int guard;
    guard = 0;
    bus.din_valid_i = 1'b1;
    bus.din_i       = d;
    bus.line_idx_i  = li;
    while (!bus.din_ready_o && guard < 200) begin
      @(negedge clk);
      guard++;
      stall_cnt++;
    end
    if (guard >= 200) check_val("hs_timeout", 509'(guard), 509'(0));
    @(negedge clk);
    bus.din_valid_i = 1'b0;
  endtask

  logic [49:0] w1[10];
  logic [49:0] wb[3][10];
  logic [49:0] wp[2][10];
  logic [49:0] wn[10];
  logic [49:0] wr[10];

  initial begin
    bus.din_valid_i  = 1'b0;
    bus.din_i        = '0;
    bus.line_idx_i   = '0;
    bus.line_abort_i = 1'b0;
    bus.fifoFull_i   = 1'b0;

    #1 rst = 1'b1;
    repeat (2) @(negedge clk);
    check_val("rst_ready",   509'(bus.din_ready_o), 509'(0));
    check_val("rst_fifo_wr", 509'(bus.fifoWr_o),   509'(0));
    check_val("rst_fifo_din", bus.fifoDin_o,       509'(0));
    check_val("rst_line_cnt", 509'(bus.line_cnt_o), 509'(0));
    rst = 1'b0;
    @(negedge clk);
    check_val("ready_after_rst", 509'(bus.din_ready_o), 509'(1));

    // Single line, words k+1, index 5
    wr_q.delete(); wr_cyc.delete();
    for (int k = 0; k < 10; k++) w1[k] = 50'(k + 1);
    for (int k = 0; k < 10; k++) send(w1[k], 9'd5);
    check_val("l1_wr_next_cycle", 509'(bus.fifoWr_o), 509'(1));
    check_val("l1_idx",    509'(bus.fifoDin_o[508:500]), 509'(5));
    check_val("l1_chunk9", 509'(bus.fifoDin_o[499:450]), 509'(50'h2_0000_0000_0000));
    check_val("l1_chunk0", 509'(bus.fifoDin_o[49:0]),    509'(50'h1_4000_0000_0000));
    check_val("l1_data",   bus.fifoDin_o, mk_line(9'd5, w1));
    @(negedge clk);
    check_val("l1_wr_single_pulse", 509'(bus.fifoWr_o),   509'(0));
    check_val("l1_line_cnt",        509'(bus.line_cnt_o), 509'(1));
    check_val("l1_num_writes",      509'(wr_q.size()),    509'(1));

    // Back-to-back lines 0,1,2
    wr_q.delete(); wr_cyc.delete();
    stall_cnt = 0;
    for (int l = 0; l < 3; l++)
      for (int k = 0; k < 10; k++) wb[l][k] = {9'(l + 1), 41'(k * 37 + 3)};
    for (int l = 0; l < 3; l++)
      for (int k = 0; k < 10; k++) send(wb[l][k], 9'(l));
    repeat (2) @(negedge clk);
    check_val("b2b_no_stall",   509'(stall_cnt),   509'(0));
    check_val("b2b_num_writes", 509'(wr_q.size()), 509'(3));
    check_val("b2b_gap01", 509'(wr_cyc[1] - wr_cyc[0]), 509'(10));
    check_val("b2b_gap12", 509'(wr_cyc[2] - wr_cyc[1]), 509'(10));
    for (int l = 0; l < 3; l++) check_val($sformatf("b2b_line%0d", l), wr_q[l], mk_line(9'(l), wb[l]));
    check_val("b2b_line_cnt", 509'(bus.line_cnt_o), 509'(4));

    // FIFO full: two lines buffered, then ready drops
    wr_q.delete(); wr_cyc.delete();
    bus.fifoFull_i = 1'b1;
    for (int l = 0; l < 2; l++)
      for (int k = 0; k < 10; k++) wp[l][k] = 50'h3_0000_0000_0000 ^ 50'((l * 10 + k) * 4369);
    for (int l = 0; l < 2; l++)
      for (int k = 0; k < 10; k++) send(wp[l][k], 9'(7 + l));
    check_val("bp_ready_drop", 509'(bus.din_ready_o), 509'(0));
    repeat (18) @(negedge clk);
    check_val("bp_ready_held",  509'(bus.din_ready_o), 509'(0));
    check_val("bp_no_wr",       509'(bus.fifoWr_o),    509'(0));
    check_val("bp_no_writes",   509'(wr_q.size()),     509'(0));
    bus.fifoFull_i = 1'b0;
    repeat (3) @(negedge clk);
    check_val("bp_num_writes",  509'(wr_q.size()), 509'(2));
    check_val("bp_consecutive", 509'(wr_cyc[1] - wr_cyc[0]), 509'(1));
    check_val("bp_line_a", wr_q[0], mk_line(9'd7, wp[0]));
    check_val("bp_line_b", wr_q[1], mk_line(9'd8, wp[1]));
    check_val("bp_line_cnt",    509'(bus.line_cnt_o),  509'(6));
    check_val("bp_ready_back",  509'(bus.din_ready_o), 509'(1));

    // Abort after word 4, together with a valid word
    wr_q.delete(); wr_cyc.delete();
    for (int k = 0; k < 4; k++) send(50'(20'hdead0 + k), 9'd3);
    bus.din_valid_i  = 1'b1;
    bus.din_i        = 50'h2_aaaa_aaaa_aaaa;
    bus.line_idx_i   = 9'd3;
    bus.line_abort_i = 1'b1;
    @(negedge clk);
    bus.line_abort_i = 1'b0;
    bus.din_valid_i  = 1'b0;
    for (int k = 0; k < 10; k++) wn[k] = 50'h1_2345_0000_0000 | 50'(k * 257);
    for (int k = 0; k < 10; k++) send(wn[k], (k == 0) ? 9'd9 : 9'(100 + k));
    repeat (2) @(negedge clk);
    check_val("ab_num_writes", 509'(wr_q.size()), 509'(1));
    check_val("ab_idx",  509'(wr_q[0][508:500]), 509'(9));
    check_val("ab_data", wr_q[0], mk_line(9'd9, wn));
    check_val("ab_line_cnt", 509'(bus.line_cnt_o), 509'(7));

    // Reset after word 7
    wr_q.delete(); wr_cyc.delete();
    for (int k = 0; k < 7; k++) send(50'(k + 500), 9'd1);
    rst = 1'b1;
    #1;
    check_val("mr_ready",    509'(bus.din_ready_o), 509'(0));
    check_val("mr_fifo_wr",  509'(bus.fifoWr_o),    509'(0));
    check_val("mr_fifo_din", bus.fifoDin_o,         509'(0));
    check_val("mr_line_cnt", 509'(bus.line_cnt_o),  509'(0));
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    for (int k = 0; k < 10; k++) wr[k] = 50'h0_0f0f_0000_0000 + 50'(k * 3);
    for (int k = 0; k < 10; k++) send(wr[k], 9'd42);
    repeat (2) @(negedge clk);
    check_val("mr_num_writes", 509'(wr_q.size()), 509'(1));
    check_val("mr_data", wr_q[0], mk_line(9'd42, wr));
    check_val("mr_line_cnt_after", 509'(bus.line_cnt_o), 509'(1));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
